// File: rtl/vec_pkg.sv
// Shared definitions for the vector coprocessor operand path: loader state
// encoding and the default word width / vector length used by the RX control
// FSM, this loader and the coprocessor core.
package vec_pkg;

  localparam int DATA_W_DFLT  = 10;
  localparam int VEC_LEN_DFLT = 1024;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } loader_state_t;

endpackage

// File: rtl/vec_mem_loader_elem_counter.sv
// Element index counter with explicit wrap at VEC_LEN-1, so non power-of-two
// vector lengths wrap correctly. Also used by the coprocessor read side.
module elem_counter #(
  parameter int VEC_LEN = 1024,
  parameter int ADDR_W  = $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(VEC_LEN - 1);

  assign tc = (cnt == LAST);

  // Count accepted elements, wrapping to zero after the last one.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/vec_mem_loader.sv
// Steers the received word stream into operand memory A, then B, and holds
// off further loading until the compute side acknowledges the pair.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  LOAD_A | accepting words into vector memory A
//  LOAD_B | accepting words into vector memory B
//  FULL   | A and B loaded; words dropped (overrun) until consume_ack
module vec_mem_loader
  import vec_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int VEC_LEN = VEC_LEN_DFLT,
  parameter int ADDR_W  = $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              clear_in,
  input  logic              consume_ack,
  output logic              mem_a_we,
  output logic              mem_b_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              vectors_ready,
  output logic              busy,
  output logic              overrun
);

  loader_state_t     state;
  logic [ADDR_W-1:0] elem_cnt;
  logic              elem_tc;
  logic              accept;

  // A word is taken whenever we are still filling A or B.
  assign accept = wr_en_in && (state != FULL);

  elem_counter #(
    .VEC_LEN (VEC_LEN),
    .ADDR_W  (ADDR_W)
  ) u_elem_counter (
    .clk (clk),
    .rst (rst),
    .clr (clear_in),
    .inc (accept),
    .cnt (elem_cnt),
    .tc  (elem_tc)
  );

  // Partial progress exists once the counter has moved, or at any point in B.
  assign busy = (elem_cnt != '0) || (state == LOAD_B);

  // Load sequencing with registered memory-side and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD_A;
      mem_a_we      <= 1'b0;
      mem_b_we      <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      vectors_ready <= 1'b0;
      overrun       <= 1'b0;
    end else if (clear_in) begin
      // Memory contents and the last written data are deliberately kept.
      state         <= LOAD_A;
      mem_a_we      <= 1'b0;
      mem_b_we      <= 1'b0;
      mem_addr      <= '0;
      vectors_ready <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      mem_a_we <= 1'b0;
      mem_b_we <= 1'b0;
      case (state)
        LOAD_A: begin
          if (wr_en_in) begin
            mem_a_we  <= 1'b1;
            mem_addr  <= elem_cnt;
            mem_wdata <= wr_data_in;
            if (elem_tc) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (wr_en_in) begin
            mem_b_we  <= 1'b1;
            mem_addr  <= elem_cnt;
            mem_wdata <= wr_data_in;
            if (elem_tc) begin
              state         <= FULL;
              vectors_ready <= 1'b1;
            end
          end
        end
        FULL: begin
          if (wr_en_in) overrun <= 1'b1;
          if (consume_ack) begin
            state         <= LOAD_A;
            vectors_ready <= 1'b0;
          end
        end
        default: begin
          state         <= LOAD_A;
          vectors_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_loader.sv
// Scoreboard bench for vec_mem_loader with a short vector length. The model
// tracks only how many words of the current A/B pair have been accepted.
module tb_vec_mem_loader;

  localparam int DW = 10;
  localparam int L  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en_in;
  logic [DW-1:0] wr_data_in;
  logic          clear_in;
  logic          consume_ack;
  logic          mem_a_we;
  logic          mem_b_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          vectors_ready;
  logic          busy;
  logic          overrun;

  vec_mem_loader #(
    .DATA_W  (DW),
    .VEC_LEN (L),
    .ADDR_W  (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en_in      (wr_en_in),
    .wr_data_in    (wr_data_in),
    .clear_in      (clear_in),
    .consume_ack   (consume_ack),
    .mem_a_we      (mem_a_we),
    .mem_b_we      (mem_b_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .vectors_ready (vectors_ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit to_b;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  n        = 0;   // words accepted into the current pair, 0..2L
  bit  m_ovr    = 0;
  int  m_addr   = 0;
  int  m_wdata  = 0;
  bit  mon_en   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances right after the edge.
  task automatic step(input bit r, input bit w, input int d, input bit c, input bit a);
    logic [DW-1:0] dd;
    bit full;
    dd = DW'(d);
    @(negedge clk);
    rst = r; wr_en_in = w; wr_data_in = dd; clear_in = c; consume_ack = a;
    @(posedge clk);
    #1;
    full = (n == 2 * L);
    if (r) begin
      n = 0; m_ovr = 0; m_addr = 0; m_wdata = 0;
    end else if (c) begin
      n = 0; m_ovr = 0; m_addr = 0;
    end else begin
      if (w) begin
        if (!full) begin
          exp_q.push_back('{n >= L, n % L, int'(dd)});
          m_addr  = n % L;
          m_wdata = int'(dd);
          n++;
        end else begin
          m_ovr = 1;
        end
      end
      if (a && full) n = 0;
    end
  endtask

  // Monitor: every expected write must show up in the very next cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      if (mem_a_we && mem_b_we) chk("we_exclusive", 1, 0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_we", int'(mem_a_we), int'(!e.to_b));
        chk("b_we", int'(mem_b_we), int'(e.to_b));
        chk("wr_addr", int'(mem_addr), e.addr);
        chk("wr_data", int'(mem_wdata), e.data);
      end else begin
        chk("a_we_idle", int'(mem_a_we), 0);
        chk("b_we_idle", int'(mem_b_we), 0);
      end
      chk("addr_hold", int'(mem_addr), m_addr);
      chk("wdata_hold", int'(mem_wdata), m_wdata);
      chk("ready", int'(vectors_ready), int'(n == 2 * L));
      chk("busy", int'(busy), int'(n > 0 && n < 2 * L));
      chk("overrun", int'(overrun), int'(m_ovr));
    end
  end

  initial begin
    rst = 1'b1; wr_en_in = 1'b0; wr_data_in = '0; clear_in = 1'b0; consume_ack = 1'b0;
    repeat (3) step(1, 0, 0, 0, 0);
    mon_en = 1;

    // Full A/B fill, overrun while FULL, acknowledge, restart in A.
    for (int i = 1; i <= 8; i++) step(0, 1, i, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 9, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 10, 0, 0);
    step(0, 0, 0, 0, 0);

    // Widely spaced strobes across the A->B boundary.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 100 + i, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end

    // Clear mid-load, after an overrun.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 200 + i, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 300 + i, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 400, 0, 0);
    step(0, 0, 0, 0, 0);

    // Acknowledge and strobe together while FULL.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 500 + i, 0, 0);
    step(0, 1, 600, 0, 1);
    step(0, 1, 601, 0, 0);
    step(0, 0, 0, 0, 0);

    // Acknowledge ignored during LOAD_B.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 700 + i, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 710, 0, 0);
    step(0, 1, 711, 0, 1);
    step(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(199) == 0,
           $urandom_range(99) < 60,
           int'($urandom_range(1023)),
           $urandom_range(99) < 3,
           $urandom_range(99) < 15);
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_mem_loader.md
Name: vec_mem_loader

Overview:
- Sits directly downstream of the UART receive control FSM.
- Consumes its one-cycle write strobe and 10-bit data word.
- Steers the incoming word stream into the two operand vector memories (A, then B) of the vector coprocessor, generating addresses.
- Holds off further loading until the compute side acknowledges the operand pair.

Parameters:
- DATA_W, 10, width of each received word and memory data port
- VEC_LEN, 1024, elements per operand vector; must be at least 2
- ADDR_W, $clog2(VEC_LEN), memory address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en_in  in  1  one-cycle strobe from the RX control FSM: word valid
- wr_data_in  in  DATA_W  received word, valid when wr_en_in=1
- clear_in  in  1  synchronous soft clear: abort the current load
- consume_ack  in  1  compute side has taken the A/B pair
- mem_a_we  out  1  write enable, vector memory A
- mem_b_we  out  1  write enable, vector memory B
- mem_addr  out  ADDR_W  shared write address for A/B
- mem_wdata  out  DATA_W  shared write data for A/B
- vectors_ready  out  1  level: A and B both fully loaded
- busy  out  1  a load is in progress (elem_cnt≠0 or state=LOAD_B)
- overrun  out  1  sticky: a word arrived while FULL and was dropped

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Priority: rst > clear_in > normal operation.
- Reset values:
  - state=LOAD_A, elem_cnt=0.
  - All outputs 0: mem_a_we, mem_b_we, mem_addr, mem_wdata, vectors_ready, busy, overrun.
- clear_in=1 has the same effect as rst, except mem_wdata is not cleared.
- FSM states: LOAD_A, LOAD_B, FULL.
- LOAD_A, on wr_en_in:
  - Next cycle: mem_a_we=1, mem_addr=elem_cnt, mem_wdata=wr_data_in.
  - elem_cnt increments.
  - If elem_cnt==VEC_LEN-1: elem_cnt wraps to 0 and state→LOAD_B.
- LOAD_B, on wr_en_in:
  - Same as LOAD_A, but mem_b_we=1.
  - At elem_cnt==VEC_LEN-1: elem_cnt→0, state→FULL.
- FULL:
  - vectors_ready=1, registered: asserted the cycle after the last B write strobe.
  - wr_en_in: word dropped, no memory write, overrun←1.
  - consume_ack: state→LOAD_A, vectors_ready→0 next cycle.
  - consume_ack and wr_en_in in the same cycle: word dropped, overrun set, then return to LOAD_A.
- consume_ack outside FULL is ignored.
- Latency: exactly 1 cycle from wr_en_in to mem_*_we. All memory-side outputs are registered.
- mem_a_we and mem_b_we are never high together. Each is high for exactly one cycle per accepted word.
- Back-to-back strobes on consecutive cycles are accepted at full rate. The A→B boundary has no bubble.
- mem_wdata and mem_addr hold their last values when no write is issued.
- overrun clears only on rst or clear_in.
- Reset or clear mid-load discards partial progress: the next word goes to A address 0. Memory contents are not erased.
- elem_cnt is ADDR_W bits. Wrap is explicit at VEC_LEN-1, so it is correct when VEC_LEN is not a power of two.

Decomposition:
- Package vec_pkg:
  - loader_state_t enum {LOAD_A, LOAD_B, FULL}
  - DATA_W and VEC_LEN defaults, shared with the RX control FSM and the coprocessor core
- Sub-module elem_counter: ADDR_W-bit counter with inc, clr, and terminal-count output at VEC_LEN-1. It is natural and reused by the coprocessor's read side.

Test Plan (VEC_LEN=4):
- Reset, then 8 strobes with data 1..8 on consecutive cycles:
  - A gets 1..4 at addr 0..3.
  - B gets 5..8 at addr 0..3.
  - Each write appears 1 cycle after its strobe.
  - vectors_ready=1 the cycle after the 8th strobe.
  - overrun=0.
- After that, strobe data 9 while FULL → no we; overrun=1. Then consume_ack → vectors_ready=0; next word 10 goes to A addr 0.
- Strobes 3 cycles apart: addresses increment only on strobes; busy stays 1 between strobes.
- 3 words loaded, then clear_in pulse → busy=0, state LOAD_A; next word goes to A addr 0; overrun cleared.
- FULL with consume_ack and wr_en_in in the same cycle → word dropped, overrun=1, next word goes to A addr 0.
- consume_ack pulsed during LOAD_B at elem_cnt=2 → ignored; remaining 2 words go to B addr 2..3.
